// File: rtl/i_memory_loader.sv
// rtl/i_memory_loader.sv - instruction memory with hardware clear, stream program load and registered fetch port
module i_memory_loader #(
    parameter int ISIZE = 16,
    parameter int MEM_SPACE = 8,
    parameter logic [ISIZE-1:0] NOP_WORD = 16'h7000,
    parameter logic [ISIZE-1:0] FILL_WORD = 16'h0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_SPACE-1:0] address,
    input  logic                 fetch_en,
    output logic [ISIZE-1:0]     data_out,
    output logic                 fetch_valid,
    input  logic                 load_valid,
    input  logic [ISIZE-1:0]     load_data,
    input  logic                 load_last,
    output logic                 load_ready,
    input  logic                 reload,
    output logic                 ready,
    output logic [MEM_SPACE:0]   load_count
);

    localparam int DEPTH = 2 ** MEM_SPACE;
    localparam logic [MEM_SPACE-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [ISIZE-1:0]     mem [DEPTH];
    logic [MEM_SPACE-1:0] clr_addr;
    logic [MEM_SPACE-1:0] load_addr;

    logic                 accept;
    logic                 load_done;
    logic                 clear_done;
    logic                 run_fetch;
    logic                 mem_we;
    logic [MEM_SPACE-1:0] mem_waddr;
    logic [ISIZE-1:0]     mem_wdata;

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_done  = 1'b0;
        clear_done = 1'b0;
        run_fetch  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = clr_addr;
        mem_wdata  = FILL_WORD;
        case (state)
            CLEAR: begin
                mem_we     = 1'b1;
                clear_done = (clr_addr == LAST_ADDR);
                if (clear_done) next_state = LOAD;
            end
            LOAD: begin
                accept    = load_valid && load_ready;
                // the beat that fills the last index ends the load, so nothing can wrap to 0
                load_done = accept && (load_last || (load_addr == LAST_ADDR));
                mem_we    = accept;
                mem_waddr = load_addr;
                mem_wdata = load_data;
                if (load_done) next_state = RUN;
            end
            RUN: begin
                run_fetch = fetch_en && !reload;
                if (reload) next_state = CLEAR;
            end
            default: next_state = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= CLEAR;
            clr_addr    <= '0;
            load_addr   <= '0;
            load_count  <= '0;
            load_ready  <= 1'b0;
            ready       <= 1'b0;
            fetch_valid <= 1'b0;
            data_out    <= NOP_WORD;
        end else begin
            state      <= next_state;
            load_ready <= (next_state == LOAD);
            ready      <= (next_state == RUN);

            if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
            else                clr_addr <= '0;

            if (clear_done) begin
                load_addr  <= '0;
                load_count <= '0;
            end else if (accept) begin
                load_addr  <= load_addr + 1'b1;
                load_count <= load_count + (MEM_SPACE+1)'(1);
            end

            // reload discards a same-cycle fetch; outside RUN the port shows NOP
            if (run_fetch) begin
                data_out    <= mem[address];
                fetch_valid <= 1'b1;
            end else if (state == RUN && !reload) begin
                fetch_valid <= 1'b0;
            end else begin
                data_out    <= NOP_WORD;
                fetch_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

endmodule
